// File: rtl/cpu_step_ctrl.sv
// CPU execution controller: single-step, divided free-run and PC-breakpoint halt.
// Breakpoint logic is built only when CPU_STEP_BREAKPOINT_EN is defined.
module cpu_step_ctrl #(
    parameter int RATE_DIV = 5000,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    output logic             cpu_ce,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    localparam int PS_W = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        STEP = 2'b01,
        RUN  = 2'b10,
        BRK  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic              ce_q, ce_d;
    logic              halted_q;
    logic              step_q;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              step_edge;
    logic              ps_term;
    logic              bp_hit;

    assign step_edge = step_btn & ~step_q;
    assign ps_term   = (ps_q == PS_LAST);

`ifdef CPU_STEP_BREAKPOINT_EN
    assign bp_hit = bp_en && (pc == bp_addr);
`else
    logic bp_unused;
    assign bp_unused = ^{bp_en, bp_addr, pc};
    assign bp_hit    = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ce_d    = 1'b0;
        ps_d    = ps_q;
        case (state_q)
            IDLE: begin
                if (run_sw) begin
                    state_d = RUN;
                    ps_d    = '0;
                end else if (step_edge) begin
                    state_d = STEP;
                    ce_d    = 1'b1;
                end
            end
            STEP: state_d = IDLE;
            RUN: begin
                // Leaving RUN wins over a terminal count; the pending pulse is dropped.
                if (!run_sw) begin
                    state_d = IDLE;
                    ps_d    = '0;
                end else begin
                    ps_d = ps_term ? '0 : ps_q + PS_W'(1);
                    if (ps_term) begin
                        if (bp_hit) state_d = BRK;
                        else        ce_d    = 1'b1;
                    end
                end
            end
            BRK: begin
                if (!run_sw) begin
                    state_d = IDLE;
                end else if (step_edge) begin
                    state_d = STEP;
                    ce_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ce_q     <= 1'b0;
            halted_q <= 1'b1;
            step_q   <= 1'b0;
            ps_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            halted_q <= (state_d != RUN);
            step_q   <= step_btn;
            ps_q     <= ps_d;
            cnt_q    <= cnt_q + CNT_W'(ce_q);
        end
    end

    assign cpu_ce      = ce_q;
    assign state       = state_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Randomised and directed bench for cpu_step_ctrl against a cycle-level behavioural model.
module tb_cpu_step_ctrl;

    localparam int RATE_DIV = 4;
    localparam int CNT_W    = 4;
`ifdef CPU_STEP_BREAKPOINT_EN
    localparam bit BP_ON = 1'b1;
`else
    localparam bit BP_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             step_btn = 1'b0;
    logic             run_sw = 1'b0;
    logic [31:0]      pc = '0;
    logic [31:0]      bp_addr = '0;
    logic             bp_en = 1'b0;
    logic             cpu_ce;
    logic [1:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 step, 2 run, 3 break; age counts cycles spent in RUN.
    int m_mode = 0;
    bit m_ce   = 0;
    int m_cnt  = 0;
    bit m_prev = 0;
    int m_age  = 0;

    cpu_step_ctrl #(.RATE_DIV(RATE_DIV), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .step_btn(step_btn), .run_sw(run_sw),
        .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
        .cpu_ce(cpu_ce), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit edge_s;
        bit ce_next;
        int mode_n;
        edge_s  = step_btn && !m_prev;
        ce_next = 1'b0;
        mode_n  = m_mode;
        if (rst) begin
            m_mode = 0; m_ce = 0; m_cnt = 0; m_prev = 0; m_age = 0;
            return;
        end
        m_cnt = (m_cnt + int'(m_ce)) % (1 << CNT_W);
        case (m_mode)
            0: if (run_sw) begin mode_n = 2; m_age = 0; end
               else if (edge_s) begin mode_n = 1; ce_next = 1; end
            1: mode_n = 0;
            2: if (!run_sw) mode_n = 0;
               else begin
                   m_age++;
                   if (m_age % RATE_DIV == 0) begin
                       if (BP_ON && bp_en && pc == bp_addr) mode_n = 3;
                       else ce_next = 1;
                   end
               end
            default: if (!run_sw) mode_n = 0;
                     else if (edge_s) begin mode_n = 1; ce_next = 1; end
        endcase
        m_mode = mode_n;
        m_ce   = ce_next;
        m_prev = step_btn;
    endtask

    function automatic logic [CNT_W+3:0] model_vec();
        return {m_ce, 2'(m_mode), (m_mode != 2), CNT_W'(m_cnt)};
    endfunction

    // Advance one clock; afterwards we sit at the falling edge, away from sampling.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run_sw = 1'b1; step_btn = 1'b0; bp_en = 1'b0;
        repeat (2) cycle();
        checks++;
        if ({cpu_ce, state, halted, instr_count} !== {1'b0, 2'b00, 1'b1, CNT_W'(0)}) begin
            errors++;
            $display("FAIL reset_state: got ce=%b st=%b h=%b cnt=%0d want ce=0 st=00 h=1 cnt=0",
                     cpu_ce, state, halted, instr_count);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (state !== 2'b10 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_run: got st=%b h=%b want st=10 h=0", state, halted);
        end
        run_sw = 1'b0;
        cycle();
    endtask

    task automatic test_single_step();
        int pulses;
        rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        step_btn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            pulses += int'(cpu_ce);
            if (i == 0) begin
                checks++;
                if (cpu_ce !== 1'b1 || state !== 2'b01) begin
                    errors++;
                    $display("FAIL step_latency: got ce=%b st=%b want ce=1 st=01", cpu_ce, state);
                end
            end
        end
        checks++;
        if (pulses != 1 || instr_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL step_single_pulse: got pulses=%0d cnt=%0d want 1 and 1", pulses, instr_count);
        end
        step_btn = 1'b0;
        cycle();
        step_btn = 1'b1;
        repeat (3) cycle();
        step_btn = 1'b0;
        cycle();
        checks++;
        if (instr_count !== CNT_W'(2)) begin
            errors++;
            $display("FAIL step_second_press: got cnt=%0d want 2", instr_count);
        end
    endtask

    task automatic test_free_run();
        int pulses;
        rst = 1'b1; run_sw = 1'b1; step_btn = 1'b0; bp_en = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            pulses += int'(cpu_ce);
            checks++;
            if ({cpu_ce, state, halted, instr_count} !== model_vec()) begin
                errors++;
                $display("FAIL run_cycle%0d: got %h want %h", i, {cpu_ce, state, halted, instr_count}, model_vec());
            end
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL run_pulse_count: got %0d want 5", pulses);
        end
        run_sw = 1'b0;
        cycle();
        checks++;
        if (state !== 2'b00 || instr_count !== CNT_W'(5)) begin
            errors++;
            $display("FAIL run_stop: got st=%b cnt=%0d want st=00 cnt=5", state, instr_count);
        end
        pulses = 0;
        repeat (8) begin
            cycle();
            pulses += int'(cpu_ce);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL run_stopped_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_breakpoint();
        rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0;
        cycle();
        rst = 1'b0;
        pc = 32'h0; bp_addr = 32'h10; bp_en = 1'b1;
        cycle();
        run_sw = 1'b1;
        for (int i = 0; i < 25; i++) begin
            cycle();
            if (m_ce) pc = pc + 32'd4;
        end
        checks++;
        if (BP_ON) begin
            if (state !== 2'b11 || cpu_ce !== 1'b0 || instr_count !== CNT_W'(4)) begin
                errors++;
                $display("FAIL bp_halt: got st=%b ce=%b cnt=%0d want st=11 ce=0 cnt=4", state, cpu_ce, instr_count);
            end
        end else begin
            if (state !== 2'b10 || instr_count !== CNT_W'(5)) begin
                errors++;
                $display("FAIL bp_ignored: got st=%b cnt=%0d want st=10 cnt=5", state, instr_count);
            end
        end
        step_btn = 1'b1;
        cycle();
        if (m_ce) pc = pc + 32'd4;
        checks++;
        if (BP_ON && (state !== 2'b01 || cpu_ce !== 1'b1)) begin
            errors++;
            $display("FAIL bp_step: got st=%b ce=%b want st=01 ce=1", state, cpu_ce);
        end
        step_btn = 1'b0;
        repeat (2) begin
            cycle();
            if (m_ce) pc = pc + 32'd4;
        end
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL bp_resume: got st=%b want st=10", state);
        end
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (m_ce) pc = pc + 32'd4;
            checks++;
            if ({cpu_ce, state, halted, instr_count} !== model_vec()) begin
                errors++;
                $display("FAIL bp_cycle%0d: got %h want %h", i, {cpu_ce, state, halted, instr_count}, model_vec());
            end
        end
        run_sw = 1'b0; bp_en = 1'b0;
        cycle();
    endtask

    task automatic test_priority_wrap();
        rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        run_sw = 1'b1; step_btn = 1'b1;
        cycle();
        checks++;
        if (state !== 2'b10 || cpu_ce !== 1'b0) begin
            errors++;
            $display("FAIL prio_run_over_step: got st=%b ce=%b want st=10 ce=0", state, cpu_ce);
        end
        step_btn = 1'b0;
        repeat (64) cycle();
        checks++;
        if (instr_count !== CNT_W'(15)) begin
            errors++;
            $display("FAIL wrap_pre: got cnt=%0d want 15", instr_count);
        end
        cycle();
        checks++;
        if (instr_count !== CNT_W'(0)) begin
            errors++;
            $display("FAIL wrap_zero: got cnt=%0d want 0", instr_count);
        end
        run_sw = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 24) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 39) == 0) begin
                bp_en   = $urandom_range(0, 1);
                bp_addr = pc + 32'(4 * $urandom_range(0, 3));
            end
            cycle();
            if (m_ce) pc = pc + 32'd4;
            checks++;
            if ({cpu_ce, state, halted, instr_count} !== model_vec()) begin
                errors++;
                $display("FAIL rand_cycle%0d: got %h want %h", i, {cpu_ce, state, halted, instr_count}, model_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_step();
        test_free_run();
        test_breakpoint();
        test_priority_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
